// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: stereo frame FIFO feeding a 64-SCK I2S serialiser, ticked by audio_clk_i.
// Define AUDIO_I2S_LJ_EN to add mode_lj_i for left-justified word-select timing.
module audio_i2s_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          audio_clk_i,
  input  logic                          enable_i,
  input  logic                          mono_i,
`ifdef AUDIO_I2S_LJ_EN
  input  logic                          mode_lj_i,
`endif
  input  logic                          inport_tvalid_i,
  input  logic [2*SAMPLE_W-1:0]         inport_tdata_i,
  output logic                          inport_tready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underrun_o,
  output logic                          i2s_sck_o,
  output logic                          i2s_ws_o,
  output logic                          i2s_sdata_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic [5:0] k, k_inc;
  logic [63:0] shreg, frame;
  logic [SAMPLE_W-1:0] head_l, head_r;
  logic lj_q, lj_d, push, pop, fall, load, leave, empty;
`ifdef AUDIO_I2S_LJ_EN
  assign lj_d = mode_lj_i;
`else
  assign lj_d = 1'b0;
`endif
  assign empty           = level == '0;
  assign inport_tready_o = level != (AW+1)'(FIFO_DEPTH);
  assign fifo_level_o    = level;
  assign push            = inport_tvalid_i && inport_tready_o;
  assign fall            = state == RUN && audio_clk_i && i2s_sck_o;
  assign load            = fall && k == '0 && enable_i;
  assign leave           = fall && k == '0 && !enable_i;
  assign pop             = load && !empty;
  assign k_inc           = k + 6'd1;
  assign head_r          = mem[rd_ptr][SAMPLE_W-1:0];
  assign head_l          = mono_i ? head_r : mem[rd_ptr][2*SAMPLE_W-1:SAMPLE_W];
  // Slots are MSB-aligned in 32 bits; an empty FIFO yields a silent frame.
  assign frame = empty ? '0 : {32'(head_l) << (32 - SAMPLE_W), 32'(head_r) << (32 - SAMPLE_W)};
  always_comb begin
    state_d = state;
    if (state == IDLE && enable_i && !empty) state_d = RUN;
    else if (leave) state_d = IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= inport_tdata_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      k           <= '0;
      shreg       <= '0;
      lj_q        <= 1'b0;
      underrun_o  <= 1'b0;
      i2s_sck_o   <= 1'b0;
      i2s_ws_o    <= 1'b0;
      i2s_sdata_o <= 1'b0;
    end else begin
      underrun_o <= load && empty;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push != pop) level <= push ? level + 1'b1 : level - 1'b1;
      if (state == RUN && audio_clk_i) begin
        i2s_sck_o <= !i2s_sck_o;
        if (leave) begin
          i2s_ws_o    <= 1'b0;
          i2s_sdata_o <= 1'b0;
        end else if (i2s_sck_o) begin
          // WS is 0 at k=0 in both formats, so the old lj_q is safe on the load edge.
          i2s_sdata_o <= load ? frame[63] : shreg[63];
          shreg       <= (load ? frame : shreg) << 1;
          i2s_ws_o    <= lj_q ? k[5] : k_inc[5];
          k           <= k_inc;
          if (load) lj_q <= lj_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: queue-based scoreboard for audio_i2s_tx with a frame-level reference model.
module tb_audio_i2s_tx;
  localparam int SW = 16, DEPTH = 8;
  logic clk = 0, rst = 1, audio_clk = 0, enable = 0, mono = 0, tvalid = 0, lj_m = 0;
  logic [2*SW-1:0] tdata = '0;
  logic tready, underrun, sck, ws, sdata;
  logic [$clog2(DEPTH):0] level;
  int vec = 0, miss = 0, tick_mode = 2, push_now = 0;
  int k_m = 0, frames_done = 0, und_cnt = 0, base, u0;
  logic [63:0] exp_q [$];
  logic en_s = 0, rst_s = 1;
  bit idle_m = 1, prev_sck = 0, cur_lj = 0;
  logic [63:0] cur_exp, got_d, got_w, last_frame, last_ws;

  always #5 clk = ~clk;

  audio_i2s_tx #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .audio_clk_i(audio_clk), .enable_i(enable), .mono_i(mono),
`ifdef AUDIO_I2S_LJ_EN
    .mode_lj_i(lj_m),
`endif
    .inport_tvalid_i(tvalid), .inport_tdata_i(tdata), .inport_tready_o(tready),
    .fifo_level_o(level), .underrun_o(underrun), .i2s_sck_o(sck), .i2s_ws_o(ws),
    .i2s_sdata_o(sdata));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    vec++;
    if (got !== want) begin
      miss++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic timeout(input string name);
    vec++;
    miss++;
    $display("FAIL timeout %s", name);
  endtask

  function automatic logic [63:0] mk(input logic [31:0] d, input bit m);
    logic [15:0] l = m ? d[15:0] : d[31:16];
    return {l, 16'h0, d[15:0], 16'h0};
  endfunction

  function automatic logic [63:0] ws_pat(input bit lj);
    logic [63:0] p = '0;
    for (int k = 0; k < 64; k++) p[63-k] = lj ? (k >= 32) : (((k + 1) % 64) >= 32);
    return p;
  endfunction

  // Reference FIFO: accepted frames are queued as fully formatted expected frames.
  always @(posedge clk) begin
    en_s <= enable;
    rst_s <= rst;
    push_now = 0;
    if (rst) exp_q.delete();
    else if (tvalid && exp_q.size() < DEPTH) begin
      exp_q.push_back(mk(tdata, mono));
      push_now = 1;
    end
  end

  always @(posedge clk) begin
    #1;
    audio_clk = tick_mode == 0 ? 1'b1 : tick_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitor: follows SCK falling edges, assembles frames and scores them against the queue.
  always @(negedge clk) begin
    bit und_exp;
    und_exp = 0;
    if (rst_s) begin
      k_m = 0;
      idle_m = 1;
    end else if (prev_sck && !sck) begin
      if (k_m == 0 && !en_s) begin
        idle_m = 1;
        chk("leave_outputs", {61'd0, sck, ws, sdata}, 64'd0);
      end else begin
        if (k_m == 0) begin
          idle_m = 0;
          und_exp = exp_q.size() == push_now;
          cur_exp = und_exp ? 64'd0 : exp_q.pop_front();
          cur_lj = lj_m;
        end
        got_d[63-k_m] = sdata;
        got_w[63-k_m] = ws;
        k_m = (k_m + 1) % 64;
        if (k_m == 0) begin
          chk("frame_data", got_d, cur_exp);
          chk("frame_ws", got_w, ws_pat(cur_lj));
          last_frame = got_d;
          last_ws = got_w;
          frames_done++;
        end
      end
    end
    if (underrun === 1'b1) und_cnt++;
    chk("underrun", 64'(underrun), 64'(und_exp));
    chk("level", 64'(level), 64'(exp_q.size()));
    chk("ready", 64'(tready), 64'(exp_q.size() < DEPTH));
    prev_sck = sck;
  end

  task automatic push(input logic [31:0] d);
    @(posedge clk) #1 tvalid = 1;
    tdata = d;
    @(posedge clk) #1 tvalid = 0;
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (frames_done >= n) return;
    end
    timeout("frames");
  endtask

  task automatic wait_k(input int k);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (k_m == k && !idle_m) return;
    end
    timeout("k");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (idle_m) return;
    end
    timeout("idle");
  endtask

  task automatic reset_pulse();
    @(posedge clk) #1 rst = 1;
    @(posedge clk) #1 rst = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_outputs", {59'd0, tready, underrun, sck, ws, sdata}, 64'h10);
    chk("rst_level", 64'(level), 64'd0);
    // Fill without ticks, then one extra push that must be refused.
    push(32'hA5A5_0F0F);
    repeat (7) push($urandom);
    push($urandom);
    @(negedge clk);
    chk("full_ready", 64'(tready), 64'd0);
    chk("full_level", 64'(level), 64'd8);
    @(posedge clk) #1 enable = 1;
    tick_mode = 0;
    wait_frames(1);
    @(negedge clk);
    chk("first_frame", last_frame, 64'hA5A5_0000_0F0F_0000);
    chk("first_ws", last_ws, 64'h0000_0001_FFFF_FFFE);
    chk("after_load_level", 64'(level), 64'd7);
    chk("after_load_ready", 64'(tready), 64'd1);
    // Random tick spacing with pushes while running, then drain into underruns.
    tick_mode = 1;
    repeat (4) push($urandom);
    wait_frames(14);
    // Disable mid-frame with fresh frames waiting: they must survive into IDLE.
    tick_mode = 0;
    wait_k(11);
    push($urandom);
    push($urandom);
    enable = 0;
    wait_idle();
    @(negedge clk);
    chk("idle_outputs", {61'd0, sck, ws, sdata}, 64'd0);
    chk("idle_level", 64'(level), 64'd2);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("idle_hold_level", 64'(level), 64'd2);
    chk("idle_hold_sck", 64'(sck), 64'd0);
    // Mono frame followed by an underrun frame.
    reset_pulse();
    mono = 1;
    base = frames_done;
    push(32'h1234_5678);
    enable = 1;
    wait_frames(base + 1);
    chk("mono_frame", last_frame, 64'h5678_0000_5678_0000);
    u0 = und_cnt;
    wait_frames(base + 2);
    chk("underrun_pulses", 64'(und_cnt - u0), 64'd1);
    chk("underrun_frame", last_frame, 64'd0);
    // Reset mid-frame.
    mono = 0;
    repeat (3) push($urandom);
    wait_k(21);
    @(posedge clk) #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs", {59'd0, tready, underrun, sck, ws, sdata}, 64'h10);
    chk("midrst_level", 64'(level), 64'd0);
    @(posedge clk) #1 rst = 0;
`ifdef AUDIO_I2S_LJ_EN
    lj_m = 1;
    base = frames_done;
    push($urandom);
    wait_frames(base + 1);
    chk("lj_ws", last_ws, 64'h0000_0000_FFFF_FFFF);
`endif
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
